clock_mode_ctrl: RTL and testbench

Front-panel controller for the digital clock hour/min/sec counters. It debounces the three raw push-buttons and sequences the operating mode: RUN, then SET_HR, SET_MIN and SET_SEC. It produces the `select_mode`, `ena_up` and `ena_dw` controls consumed by the count_* counters, plus a blink strobe for the display driver. Set modes return to RUN automatically after a period of button inactivity.

---
 rtl/clock_mode_ctrl.sv | 158 +++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
// Front-panel controller for the digital clock: debounces the mode/up/down
// buttons, sequences RUN -> SET_HR -> SET_MIN -> SET_SEC, drives the
// active-low up/down enables for the counters and a blink strobe, and
// falls back to RUN after a period of button inactivity.
module clock_mode_ctrl #(
    parameter int unsigned DEB_CYCLES = 20,
    parameter int unsigned TIMEOUT_S  = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_5hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_dw,
    output logic [1:0] select_mode,
    output logic       ena_up,
    output logic       ena_dw,
    output logic       blink
);

    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_S) + 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        SET_SEC = 2'b11
    } mode_e;

    // Button index: 0 = mode, 1 = up, 2 = down. All levels active-low.
    logic [2:0]    raw;
    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic [2:0]    deb_q, deb_d;
    logic [DW-1:0] cnt_q [3];
    logic [DW-1:0] cnt_d [3];
    logic          mode_prev_q, mode_prev_d;
    mode_e         state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ena_up_q, ena_up_d;
    logic          ena_dw_q, ena_dw_d;
    logic          blink_q, blink_d;

    logic mode_pulse, up_pressed, dw_pressed, in_set, activity, expire;

    assign raw = {btn_dw, btn_up, btn_mode};

    // Synchronizer chain and per-button debounce counters
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        for (int unsigned i = 0; i < 3; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Press decode: mode pulse is the debounced falling edge of the mode button
    always_comb begin
        mode_prev_d = deb_q[0];
        mode_pulse  = mode_prev_q & ~deb_q[0];
        up_pressed  = ~deb_q[1];
        dw_pressed  = ~deb_q[2];
        in_set      = (state_q != RUN);
        activity    = in_set & (up_pressed | dw_pressed | mode_pulse);
        expire      = in_set & tick_1hz & (tmo_q == TMO_LAST);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: mode pulse takes priority over timeout expiry
    always_comb begin
        state_d = state_q;
        if (mode_pulse) begin
            unique case (state_q)
                RUN:     state_d = SET_HR;
                SET_HR:  state_d = SET_MIN;
                SET_MIN: state_d = SET_SEC;
                SET_SEC: state_d = RUN;
            endcase
        end else if (expire) begin
            state_d = RUN;
        end
    end

    // FSM outputs: up/down enables, timeout count and blink strobe
    always_comb begin
        ena_up_d = ~(in_set & up_pressed & ~dw_pressed);
        ena_dw_d = ~(in_set & dw_pressed & ~up_pressed);

        tmo_d = tmo_q;
        if (!in_set || activity || (state_d != state_q)) begin
            tmo_d = '0;
        end else if (tick_1hz) begin
            tmo_d = tmo_q + 1'b1;
        end

        blink_d = blink_q;
        if ((state_d == RUN) || (state_d != state_q) || up_pressed || dw_pressed) begin
            blink_d = 1'b1;
        end else if (tick_5hz) begin
            blink_d = ~blink_q;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            deb_q       <= '1;
            for (int unsigned i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            mode_prev_q <= 1'b1;
            tmo_q       <= '0;
            ena_up_q    <= 1'b1;
            ena_dw_q    <= 1'b1;
            blink_q     <= 1'b1;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            for (int unsigned i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            mode_prev_q <= mode_prev_d;
            tmo_q       <= tmo_d;
            ena_up_q    <= ena_up_d;
            ena_dw_q    <= ena_dw_d;
            blink_q     <= blink_d;
        end
    end

    assign select_mode = state_q;
    assign ena_up      = ena_up_q;
    assign ena_dw      = ena_dw_q;
    assign blink       = blink_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed scenarios followed by random button
// and tick activity, with every cycle compared against a behavioural model.
module tb_clock_mode_ctrl;

    localparam int DEB = 4;
    localparam int TMO = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz, tick_5hz;
    logic       btn_mode, btn_up, btn_dw;
    logic [1:0] select_mode;
    logic       ena_up, ena_dw, blink;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clock_mode_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_S(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .tick_5hz   (tick_5hz),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_dw     (btn_dw),
        .select_mode(select_mode),
        .ena_up     (ena_up),
        .ena_dw     (ena_dw),
        .blink      (blink)
    );

    // Reference model: raw-level history per button (index 0 newest),
    // mode as an integer 0..3, idle seconds as an integer.
    bit raw_h [3][DEB+2];
    bit m_deb [3];
    bit m_prev;
    int m_mode, m_idle;
    bit m_up, m_dw, m_blink;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < DEB + 2; k++) raw_h[i][k] = 1'b1;
            m_deb[i] = 1'b1;
        end
        m_prev  = 1'b1;
        m_mode  = 0;
        m_idle  = 0;
        m_up    = 1'b1;
        m_dw    = 1'b1;
        m_blink = 1'b1;
    endfunction

    function automatic void model_step(bit r, bit rm, bit ru, bit rd, bit t1, bit t5);
        bit raw [3];
        bit pu, pd, pulse, set, act, expd, settled;
        int nm;
        if (r) begin
            model_reset();
            return;
        end
        raw[0] = rm; raw[1] = ru; raw[2] = rd;
        pu    = !m_deb[1];
        pd    = !m_deb[2];
        pulse = m_prev && !m_deb[0];
        set   = (m_mode != 0);
        act   = set && (pu || pd || pulse);
        expd  = set && t1 && (m_idle == TMO - 1);
        nm    = pulse ? (m_mode + 1) % 4 : (expd ? 0 : m_mode);
        if (nm != m_mode || act || !set) m_idle = 0;
        else if (t1) m_idle = m_idle + 1;
        m_up = !(set && pu && !pd);
        m_dw = !(set && pd && !pu);
        if (nm == 0 || nm != m_mode || pu || pd) m_blink = 1'b1;
        else if (t5) m_blink = !m_blink;
        m_mode = nm;
        m_prev = m_deb[0];
        // Synchronized level seen at this edge is the raw level from two
        // edges ago; debounced level flips once DEB such samples all differ.
        for (int i = 0; i < 3; i++) begin
            for (int k = DEB + 1; k > 0; k--) raw_h[i][k] = raw_h[i][k-1];
            raw_h[i][0] = raw[i];
            settled = 1'b1;
            for (int k = 2; k < DEB + 2; k++) if (raw_h[i][k] == m_deb[i]) settled = 1'b0;
            if (settled) m_deb[i] = !m_deb[i];
        end
    endfunction

    task automatic chk_model();
        logic [4:0] obs, exp_v;
        obs   = {select_mode, ena_up, ena_dw, blink};
        exp_v = {m_mode[1:0], m_up, m_dw, m_blink};
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL model t=%0t observed=%b expected=%b", $time, obs, exp_v);
        end
    endtask

    task automatic chk_sel(string tag, logic [1:0] exp_v);
        total++;
        assert (select_mode === exp_v) else begin
            bad++;
            $error("FAIL %s select_mode observed=%b expected=%b", tag, select_mode, exp_v);
        end
    endtask

    task automatic chk_bit(string tag, logic obs, logic exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic cycle();
        model_step(rst, btn_mode, btn_up, btn_dw, tick_1hz, tick_5hz);
        @(posedge clk);
        #1;
        chk_model();
    endtask

    task automatic cycles(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic press_mode();
        btn_mode = 1'b0;
        cycles(10);
        btn_mode = 1'b1;
        cycles(10);
    endtask

    task automatic tick1();
        tick_1hz = 1'b1;
        cycle();
        tick_1hz = 1'b0;
        cycles(3);
    endtask

    task automatic tick5();
        tick_5hz = 1'b1;
        cycle();
        tick_5hz = 1'b0;
        cycle();
    endtask

    // Mode button falling edge timed so its pulse lands on a tick_1hz cycle
    task automatic mode_with_tick();
        btn_mode = 1'b0;
        cycles(6);
        tick_1hz = 1'b1;
        cycle();
        tick_1hz = 1'b0;
    endtask

    task automatic finish_mode_press();
        cycles(3);
        btn_mode = 1'b1;
        cycles(10);
    endtask

    initial begin
        rst = 1'b1; tick_1hz = 1'b0; tick_5hz = 1'b0;
        btn_mode = 1'b1; btn_up = 1'b1; btn_dw = 1'b1;
        model_reset();
        cycles(2);
        rst = 1'b0;
        cycles(2);
        chk_sel("reset_sel", 2'b00);

        // Asynchronous reset from SET_HR with up held
        press_mode();
        btn_up = 1'b0;
        cycles(10);
        chk_bit("pre_rst_ena_up", ena_up, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_sel("async_rst_sel", 2'b00);
        chk_bit("async_rst_ena_up", ena_up, 1'b1);
        chk_bit("async_rst_ena_dw", ena_dw, 1'b1);
        chk_bit("async_rst_blink", blink, 1'b1);
        model_reset();
        cycles(2);
        rst = 1'b0;
        btn_up = 1'b1;
        cycles(4);

        // Short glitch is filtered
        btn_mode = 1'b0;
        cycles(3);
        btn_mode = 1'b1;
        cycles(8);
        chk_sel("glitch", 2'b00);

        // Press latency: 2 sync + 4 debounce + 1 register
        btn_mode = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cycle();
            if (k == 6) chk_sel("lat6", 2'b00);
            if (k == 7) chk_sel("lat7", 2'b01);
        end
        cycles(3);
        btn_mode = 1'b1;
        cycles(8);

        // Mode sequencing
        press_mode(); press_mode(); press_mode();
        chk_sel("back_run", 2'b00);
        press_mode(); chk_sel("seq1", 2'b01);
        press_mode(); chk_sel("seq2", 2'b10);
        press_mode(); chk_sel("seq3", 2'b11);
        press_mode(); chk_sel("seq0", 2'b00);
        btn_mode = 1'b0;
        cycles(100);
        chk_sel("hold100", 2'b01);
        btn_mode = 1'b1;
        cycles(10);
        chk_sel("hold100_rel", 2'b01);

        // Up/down in SET_MIN
        press_mode();
        chk_sel("set_min", 2'b10);
        btn_up = 1'b0;
        cycles(6);
        chk_bit("up_lat6", ena_up, 1'b1);
        cycle();
        chk_bit("up_lat7", ena_up, 1'b0);
        chk_bit("up_dw_idle", ena_dw, 1'b1);
        cycles(5);
        chk_bit("up_held", ena_up, 1'b0);
        btn_dw = 1'b0;
        cycles(7);
        chk_bit("both_up", ena_up, 1'b1);
        chk_bit("both_dw", ena_dw, 1'b1);
        btn_up = 1'b1; btn_dw = 1'b1;
        cycles(10);
        press_mode(); press_mode();
        chk_sel("run_again", 2'b00);
        btn_up = 1'b0;
        cycles(10);
        chk_bit("run_up", ena_up, 1'b1);
        btn_dw = 1'b0;
        cycles(10);
        chk_bit("run_dw", ena_dw, 1'b1);
        btn_up = 1'b1; btn_dw = 1'b1;
        cycles(10);

        // Timeout
        press_mode();
        tick1(); tick1();
        chk_sel("tmo_2", 2'b01);
        tick1();
        chk_sel("tmo_3", 2'b00);
        press_mode();
        tick1(); tick1();
        btn_up = 1'b0;
        cycles(8);
        btn_up = 1'b1;
        cycles(8);
        tick1(); tick1();
        chk_sel("tmo_restart_2", 2'b01);
        tick1();
        chk_sel("tmo_restart_3", 2'b00);

        // Mode pulse coinciding with expiry
        press_mode(); press_mode(); press_mode();
        chk_sel("set_sec", 2'b11);
        tick1(); tick1();
        mode_with_tick();
        chk_sel("coinc_sec", 2'b00);
        finish_mode_press();
        press_mode();
        tick1(); tick1();
        mode_with_tick();
        chk_sel("coinc_hr", 2'b10);
        finish_mode_press();

        // Blink in SET_MIN
        chk_bit("blink_entry", blink, 1'b1);
        tick5(); chk_bit("blink1", blink, 1'b0);
        tick5(); chk_bit("blink2", blink, 1'b1);
        tick5(); chk_bit("blink3", blink, 1'b0);
        tick5(); chk_bit("blink4", blink, 1'b1);
        tick5(); chk_bit("blink5", blink, 1'b0);
        btn_up = 1'b0;
        cycles(7);
        chk_bit("blink_up_force", blink, 1'b1);
        tick5(); chk_bit("blink_up_t1", blink, 1'b1);
        tick5(); chk_bit("blink_up_t2", blink, 1'b1);
        btn_up = 1'b1;
        cycles(10);
        press_mode();
        chk_sel("blink_sec", 2'b11);
        tick5(); chk_bit("blink_sec_t", blink, 1'b0);
        press_mode();
        chk_sel("blink_run_sel", 2'b00);
        chk_bit("blink_run", blink, 1'b1);

        // Random activity against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 9) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 9) == 0) btn_dw = ~btn_dw;
            tick_1hz = ($urandom_range(0, 24) == 0);
            tick_5hz = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
